simon_host_driver: RTL and testbench
====================================

// Module: simon_host_driver
// PURPOSE
// - Host-side counterpart of SIMON_control: owns newDATA/newKEY/readDATA/infoIN/countIN/inDATA/KEY.
// - Takes keys and plaintext blocks from an upstream valid/ready source and feeds them to the core.
// - Collects ciphertext on doneDATA into a small result FIFO and presents it downstream via valid/ready.
// - Checks that the returned sequence number matches the one issued.
// PARAMETERS
// - N          `N (16)  word width in bits; a block is 2 words.
// - M          `M (4)   number of key words.
// - FIFO_DEPTH 4        result FIFO entries; must be a power of 2 and at least 2.
// PORTS
// - clk        in   1       single clock; all logic is on its rising edge.
// - R          in   1       asynchronous, active-high reset.
// - key_valid  in   1       upstream key offered.
// - key_ready  out  1       key accepted on key_valid&&key_ready.
// - key_in     in   M*N     key words.
// - in_valid   in   1       upstream block offered.
// - in_ready   out  1       block accepted on in_valid&&in_ready.
// - in_block   in   2*N     plaintext.
// - in_info    in   8       info byte forwarded as infoIN.
// - out_valid  out  1       FIFO head is valid.
// - out_ready  in   1       downstream pops on out_valid&&out_ready.
// - out_block  out  2*N     ciphertext at the FIFO head.
// - out_info   out  8       infoOUT captured with the block.
// - out_count  out  8       countOUT captured with the block.
// - err        out  1       sticky: a countOUT mismatch occurred.
// - newDATA    out  1       data request to the core.
// - newKEY     out  1       key request to the core.
// - readDATA   out  1       one-cycle acknowledge of the core's result.
// - infoIN     out  8       info for the block in flight.
// - countIN    out  8       sequence number for the block in flight.
// - inDATA     out  2*N     block in flight, held stable.
// - KEY        out  M*N     current key, held stable.
// - loadDATA   in   1       core has taken the data.
// - loadKEY    in   1       core has taken the key.
// - doneDATA   in   1       core result is valid.
// - doneKEY    in   1       key schedule is complete.
// - infoOUT    in   8       info returned by the core.
// - countOUT   in   8       sequence number returned by the core.
// - outDATA    in   2*N     ciphertext returned by the core.
// BEHAVIOUR
// - Reset (async, R=1):
//   - every output and register goes to 0, FIFO is emptied, key_loaded=0, seq=0, state=IDLE.
//   - Reset mid-operation abandons the block or key in flight; no partial result is pushed.
// - FSM states: IDLE, KEY_REQ, KEY_WAIT, DATA_REQ, DATA_RUN, DATA_ACK.
// - IDLE:
//   - key_ready=1.
//   - in_ready = key_loaded && !key_valid, so a key takes priority over data.
//   - Key handshake: capture KEY, key_loaded<=0, go to KEY_REQ.
//   - Data handshake: capture inDATA and infoIN, countIN<=seq, go to DATA_REQ.
// - KEY_REQ: newKEY=1 (registered); on the edge that samples loadKEY=1, newKEY<=0 and go to KEY_WAIT.
// - KEY_WAIT: on doneKEY=1, key_loaded<=1 and go to IDLE.
// - DATA_REQ: newDATA=1 (registered); on the edge that samples loadDATA=1, newDATA<=0 and go to DATA_RUN.
// - DATA_RUN:
//   - If doneDATA=1 and the FIFO is not full: push {outDATA,infoOUT,countOUT}, pulse readDATA for exactly one cycle, go to DATA_ACK.
//   - If countOUT!=countIN, err<=1 (sticky until reset).
//   - If the FIFO is full: hold; readDATA stays 0 and doneDATA is left pending.
// - DATA_ACK: wait for doneDATA=0, then seq<=seq+1 (8-bit, wraps 255->0) and go to IDLE.
// - inDATA, KEY, infoIN and countIN change only on an accepted handshake.
// - At most one block is in flight; the key is never changed while a block is in flight.
// - Latency: in_valid accepted -> newDATA=1 on the next cycle; doneDATA seen -> out_valid=1 one cycle after the push.
// - FIFO push and pop in the same cycle are allowed when not full and not empty; the count is unchanged.
// - When the FIFO is full, a pop frees an entry but the push waits one cycle.
// STRUCTURE
// - simon_host_pkg: state_t enum and result_t struct {block[2*N], info[8], count[8]}.
// - N and M come from SIMON_defintions.svh.
// - Sub-module simon_result_fifo: synchronous FIFO with async reset.
//   - Ports: push, pop, din, dout, full, empty.
//   - Pointers are log2(FIFO_DEPTH)+1 bits.
// TESTING (bench pairs the DUT with SIMON_control, or with a behavioural responder where noted)
// - Key 1918_1110_0908_0100, then block 6565_6877 with info 8'h5A -> newKEY, then newDATA handshakes; out_block=c69b_e9bb, out_info=5A, out_count=00.
// - in_valid=1 before any key -> in_ready=0 and newDATA stays 0; after the key load completes the block is accepted.
// - out_ready=0 and 5 blocks -> 4 entries held; 5th: doneDATA=1, readDATA=0; one pop -> readDATA pulses 2 cycles later, 5th emerges.
// - Responder returns countOUT=07 for countIN=00 -> err=1 and it stays 1 through later good blocks.
// - Assert R while in DATA_RUN -> all outputs 0 immediately, state IDLE, key_loaded=0; a new key and block then complete correctly.
// - 257 blocks through the responder -> countIN sequence 00..FF then 00; readDATA is exactly one cycle per block.

Source files
------------

// File: rtl/simon_host_pkg.sv
// simon_host_pkg: shared types for the SIMON host driver.
// Word/key sizing matches the SIMON 32/64 core build.
package simon_host_pkg;

  localparam int N = 16;
  localparam int M = 4;

  typedef enum logic [2:0] {
    IDLE,
    KEY_REQ,
    KEY_WAIT,
    DATA_REQ,
    DATA_RUN,
    DATA_ACK
  } state_t;

  typedef struct packed {
    logic [2*N-1:0] block;
    logic [7:0]     info;
    logic [7:0]     count;
  } result_t;

endpackage

// File: rtl/simon_result_fifo.sv
// simon_result_fifo: synchronous result FIFO, async active-high reset.
// Pointers carry one extra wrap bit so full and empty are distinct.
module simon_result_fifo
  import simon_host_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  result_t din,
  output result_t dout,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  result_t    mem_q [DEPTH];
  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= din;
        wr_q <= wr_q + ONE;
      end
      if (do_pop) rd_q <= rd_q + ONE;
    end
  end

endmodule

// File: rtl/simon_host_driver.sv
// simon_host_driver: host side of SIMON_control; feeds keys and
// blocks to the core and queues tagged ciphertext downstream.
module simon_host_driver
  import simon_host_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           R,
  input  logic           key_valid,
  output logic           key_ready,
  input  logic [M*N-1:0] key_in,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] in_block,
  input  logic [7:0]     in_info,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_block,
  output logic [7:0]     out_info,
  output logic [7:0]     out_count,
  output logic           err,
  output logic           newDATA,
  output logic           newKEY,
  output logic           readDATA,
  output logic [7:0]     infoIN,
  output logic [7:0]     countIN,
  output logic [2*N-1:0] inDATA,
  output logic [M*N-1:0] KEY,
  input  logic           loadDATA,
  input  logic           loadKEY,
  input  logic           doneDATA,
  input  logic           doneKEY,
  input  logic [7:0]     infoOUT,
  input  logic [7:0]     countOUT,
  input  logic [2*N-1:0] outDATA
);

  state_t         state_q, state_d;
  logic [M*N-1:0] key_q, key_d;
  logic [2*N-1:0] data_q, data_d;
  logic [7:0]     info_q, info_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [7:0]     seq_q, seq_d;
  logic           kl_q, kl_d;
  logic           nd_q, nd_d;
  logic           nk_q, nk_d;
  logic           rd_q, rd_d;
  logic           err_q, err_d;
  logic           push, full, empty;
  result_t        din, dout;

  assign din = {outDATA, infoOUT, countOUT};

  simon_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (R),
    .push (push),
    .pop  (out_ready),
    .din  (din),
    .dout (dout),
    .full (full),
    .empty(empty)
  );

  // Ready is masked during reset so every output reads 0.
  assign key_ready = (state_q == IDLE) && !R;
  assign in_ready  = (state_q == IDLE) && kl_q
                     && !key_valid && !R;

  assign out_valid = !empty;
  assign out_block = dout.block;
  assign out_info  = dout.info;
  assign out_count = dout.count;
  assign err       = err_q;
  assign newDATA   = nd_q;
  assign newKEY    = nk_q;
  assign readDATA  = rd_q;
  assign infoIN    = info_q;
  assign countIN   = cnt_q;
  assign inDATA    = data_q;
  assign KEY       = key_q;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    data_d  = data_q;
    info_d  = info_q;
    cnt_d   = cnt_q;
    seq_d   = seq_q;
    kl_d    = kl_q;
    nd_d    = nd_q;
    nk_d    = nk_q;
    rd_d    = 1'b0;
    err_d   = err_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
          key_d   = key_in;
          kl_d    = 1'b0;
          nk_d    = 1'b1;
          state_d = KEY_REQ;
        end else if (in_valid && kl_q) begin
          data_d  = in_block;
          info_d  = in_info;
          cnt_d   = seq_q;
          nd_d    = 1'b1;
          state_d = DATA_REQ;
        end
      end
      KEY_REQ: begin
        if (loadKEY) begin
          nk_d    = 1'b0;
          state_d = KEY_WAIT;
        end
      end
      KEY_WAIT: begin
        if (doneKEY) begin
          kl_d    = 1'b1;
          state_d = IDLE;
        end
      end
      DATA_REQ: begin
        if (loadDATA) begin
          nd_d    = 1'b0;
          state_d = DATA_RUN;
        end
      end
      DATA_RUN: begin
        // A full FIFO leaves doneDATA pending until space frees.
        if (doneDATA && !full) begin
          push    = 1'b1;
          rd_d    = 1'b1;
          state_d = DATA_ACK;
          if (countOUT != cnt_q) err_d = 1'b1;
        end
      end
      DATA_ACK: begin
        if (!doneDATA) begin
          seq_d   = seq_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q <= IDLE;
      key_q   <= '0;
      data_q  <= '0;
      info_q  <= '0;
      cnt_q   <= '0;
      seq_q   <= '0;
      kl_q    <= 1'b0;
      nd_q    <= 1'b0;
      nk_q    <= 1'b0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      data_q  <= data_d;
      info_q  <= info_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      kl_q    <= kl_d;
      nd_q    <= nd_d;
      nk_q    <= nk_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_simon_host_driver.sv
// tb_simon_host_driver: randomized bench with a behavioural SIMON
// 32/64 core responder and a scoreboard on the result stream.
module tb_simon_host_driver;
  import simon_host_pkg::*;

  localparam int TMO = 3000;

  logic           clk;
  logic           R;
  logic           key_valid;
  logic           key_ready;
  logic [M*N-1:0] key_in;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] in_block;
  logic [7:0]     in_info;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_block;
  logic [7:0]     out_info;
  logic [7:0]     out_count;
  logic           err;
  logic           newDATA;
  logic           newKEY;
  logic           readDATA;
  logic [7:0]     infoIN;
  logic [7:0]     countIN;
  logic [2*N-1:0] inDATA;
  logic [M*N-1:0] KEY;
  logic           loadDATA;
  logic           loadKEY;
  logic           doneDATA;
  logic           doneKEY;
  logic [7:0]     infoOUT;
  logic [7:0]     countOUT;
  logic [2*N-1:0] outDATA;

  simon_host_driver dut (
    .clk(clk), .R(R),
    .key_valid(key_valid), .key_ready(key_ready),
    .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_info(in_info),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_block(out_block), .out_info(out_info),
    .out_count(out_count), .err(err),
    .newDATA(newDATA), .newKEY(newKEY),
    .readDATA(readDATA),
    .infoIN(infoIN), .countIN(countIN),
    .inDATA(inDATA), .KEY(KEY),
    .loadDATA(loadDATA), .loadKEY(loadKEY),
    .doneDATA(doneDATA), .doneKEY(doneKEY),
    .infoOUT(infoOUT), .countOUT(countOUT),
    .outDATA(outDATA)
  );

  always begin
    clk = 1'b0; #5;
    clk = 1'b1; #5;
  end

  int vec = 0;
  int mis = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    vec++;
    mis++;
    $display("FAIL %s: timeout after %0d cycles", nm, TMO);
  endtask

  // Reference SIMON 32/64 encryption.
  function automatic logic [15:0] rl(input logic [15:0] v,
                                     input int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  function automatic logic [31:0] simon_enc(input logic [63:0] key,
                                            input logic [31:0] pt);
    logic [15:0] k [32];
    logic [15:0] x, y, t;
    logic [61:0] z;
    z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t = rl(k[i-1], 13) ^ k[i-3];
      t = t ^ rl(t, 15);
      k[i] = ~k[i-4] ^ t ^ {15'd0, z[61-(i-4)]} ^ 16'd3;
    end
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      t = x;
      x = y ^ (rl(x, 1) & rl(x, 8)) ^ rl(x, 2) ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  logic [47:0] exp_q [$];
  logic [7:0]  mseq;
  logic [63:0] mkey;
  logic        hold;
  logic        bad_en;
  logic [7:0]  bad_seq;

  // Behavioural core responder.
  int          ks, ds, kdly, ddly, data_loads;
  logic [31:0] r_c;
  logic [7:0]  r_i, r_n;

  always @(negedge clk) begin
    if (R) begin
      loadKEY = 0; doneKEY = 0;
      loadDATA = 0; doneDATA = 0;
      infoOUT = '0; countOUT = '0; outDATA = '0;
      ks = 0; ds = 0; data_loads = 0;
    end else begin
      case (ks)
        0: if (newKEY) begin
          loadKEY = 1;
          kdly = $urandom_range(0, 3);
          ks = 1;
        end
        1: begin
          loadKEY = 0;
          if (kdly == 0) begin doneKEY = 1; ks = 2; end
          else kdly--;
        end
        default: begin doneKEY = 0; ks = 0; end
      endcase
      case (ds)
        0: if (newDATA) begin
          loadDATA = 1;
          data_loads++;
          r_c = simon_enc(KEY, inDATA);
          r_i = infoIN;
          r_n = (bad_en && countIN == bad_seq) ? 8'h07 : countIN;
          ddly = $urandom_range(2, 5);
          ds = 1;
        end
        1: begin
          loadDATA = 0;
          if (ddly == 0) begin
            doneDATA = 1;
            outDATA = r_c; infoOUT = r_i; countOUT = r_n;
            ds = 2;
          end else ddly--;
        end
        default: if (readDATA) begin
          doneDATA = 0;
          outDATA = $urandom;
          ds = 0;
        end
      endcase
    end
  end

  // Monitor: downstream sink and scoreboard check.
  logic        rd_prev;
  int          rd_pulses, popped;
  logic [47:0] e;

  always @(negedge clk) begin
    if (R) begin
      out_ready = 0; rd_prev = 0;
      rd_pulses = 0; popped = 0;
    end else begin
      if (rd_prev) chk("readDATA_width", 64'(readDATA), 64'(0));
      if (readDATA) rd_pulses++;
      rd_prev = readDATA;
      out_ready = !hold && ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        popped++;
        if (exp_q.size() == 0) begin
          vec++; mis++;
          $display("FAIL unexpected_out: got %h with empty queue",
                   {out_block, out_info, out_count});
        end else begin
          e = exp_q.pop_front();
          chk("out_result", 64'({out_block, out_info, out_count}),
              64'(e));
        end
      end
    end
  end

  task automatic send_key(input logic [63:0] k);
    int t;
    t = 0;
    key_in = k;
    key_valid = 1;
    while (!key_ready && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) tmo("key_handshake");
    @(negedge clk);
    key_valid = 0;
    mkey = k;
  endtask

  task automatic send_block(input logic [31:0] b,
                            input logic [7:0] inf,
                            input logic [31:0] c);
    int t;
    t = 0;
    in_block = b;
    in_info = inf;
    in_valid = 1;
    while (!in_ready && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) tmo("block_handshake");
    @(negedge clk);
    in_valid = 0;
    exp_q.push_back({c, inf,
      (bad_en && mseq == bad_seq) ? 8'h07 : mseq});
    mseq++;
  endtask

  task automatic rand_block();
    logic [31:0] b;
    b = $urandom;
    send_block(b, 8'($urandom), simon_enc(mkey, b));
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !key_ready) && t < TMO) begin
      @(negedge clk); t++;
    end
    if (t >= TMO) tmo(nm);
  endtask

  logic        viol;
  int          n, t;
  logic [31:0] b;

  initial begin
    R = 0; key_valid = 0; in_valid = 0;
    key_in = '0; in_block = '0; in_info = '0;
    hold = 0; bad_en = 0; bad_seq = '0;
    mseq = '0; mkey = '0;
    #1 R = 1;
    #1;
    chk("rst_ctl", 64'({key_ready, in_ready, out_valid, err,
        newDATA, newKEY, readDATA}), 64'(0));
    chk("rst_key", KEY, 64'(0));
    chk("rst_in", 64'({inDATA, infoIN, countIN}), 64'(0));
    chk("rst_out", 64'({out_block, out_info, out_count}), 64'(0));
    repeat (2) @(negedge clk);
    R = 0;
    @(negedge clk);
    chk("idle_key_ready", 64'(key_ready), 64'(1));

    // Block offered before any key must wait.
    in_block = 32'h6565_6877;
    in_info = 8'h5A;
    in_valid = 1;
    viol = 0;
    repeat (6) begin
      @(negedge clk);
      viol = viol | in_ready | newDATA;
    end
    chk("block_before_key", 64'(viol), 64'(0));
    send_key(64'h1918_1110_0908_0100);
    send_block(32'h6565_6877, 8'h5A, 32'hc69b_e9bb);
    drain("kat_drain");

    for (int i = 0; i < 20; i++) begin
      if (i % 7 == 3) send_key({$urandom, $urandom});
      rand_block();
    end
    drain("random_drain");

    // Stall downstream: four results fill the FIFO, fifth waits.
    hold = 1;
    for (int i = 0; i < 5; i++) rand_block();
    repeat (12) @(negedge clk);
    chk("full_doneDATA", 64'(doneDATA), 64'(1));
    chk("full_readDATA", 64'(readDATA), 64'(0));
    chk("full_out_valid", 64'(out_valid), 64'(1));
    hold = 0;
    drain("full_drain");

    // Reset while the core is running a block.
    send_key({$urandom, $urandom});
    n = data_loads;
    b = $urandom;
    send_block(b, 8'h33, simon_enc(mkey, b));
    t = 0;
    while (data_loads == n && t < TMO) begin
      @(negedge clk); t++;
    end
    if (t >= TMO) tmo("wait_load");
    @(negedge clk);
    R = 1;
    #1;
    chk("midrst_ctl", 64'({key_ready, in_ready, out_valid, err,
        newDATA, newKEY, readDATA}), 64'(0));
    chk("midrst_key", KEY, 64'(0));
    chk("midrst_in", 64'({inDATA, infoIN, countIN}), 64'(0));
    exp_q.delete();
    mseq = '0;
    repeat (2) @(negedge clk);
    R = 0;
    b = $urandom;
    in_block = b;
    in_info = 8'hC3;
    in_valid = 1;
    repeat (2) @(negedge clk);
    chk("midrst_no_key", 64'({key_ready, in_ready}), 64'(2));
    send_key({$urandom, $urandom});
    send_block(b, 8'hC3, simon_enc(mkey, b));
    drain("midrst_drain");
    chk("err_clear", 64'(err), 64'(0));

    // Core returns a wrong sequence number for one block.
    bad_seq = mseq;
    bad_en = 1;
    rand_block();
    drain("err_drain");
    bad_en = 0;
    chk("err_set", 64'(err), 64'(1));

    // Run the sequence number through its wrap.
    for (int i = 0; i < 257; i++) begin
      if (i == 100) send_key({$urandom, $urandom});
      rand_block();
    end
    drain("wrap_drain");
    chk("err_sticky", 64'(err), 64'(1));
    chk("rd_total", 64'(rd_pulses), 64'(popped));

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
